// File: rtl/uart_encoder.sv
// uart_encoder: byte-stream 8N1/8N2 UART transmitter, LSB first.
// Input FIFO with valid/ready, baud divider and frame FSM.
module uart_encoder #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4,
    parameter int STOP_BITS   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int CPB = CLK_FREQ_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int CW  = $clog2(CPB);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic            ready_q, ready_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic            empty;
    logic            full_d;
    logic            tick;
    logic            push;
    logic            pop;
    logic [7:0]      head;

    assign empty   = (wr_q == rd_q);
    assign tick    = (cnt_q == CNT_LAST);
    assign push    = i_valid && ready_q;
    assign head    = mem_q[rd_q[AW-1:0]];

    assign o_ready = ready_q;
    assign o_tx    = tx_q;
    assign o_busy  = busy_q;
    assign o_level = wr_q - rd_q;

    // Frame sequencing: next state, baud/bit counters, shifter, FIFO pop
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_d = head;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointers and registered ready (ready reflects the post-edge fill)
    always_comb begin
        wr_d    = wr_q + PW'(push);
        rd_d    = rd_q + PW'(pop);
        full_d  = (wr_d[AW] != rd_d[AW]) &&
                  (wr_d[AW-1:0] == rd_d[AW-1:0]);
        ready_d = !full_d;
    end

    // Line level and busy flag, one cycle behind the state that drives them
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_q != S_IDLE) || !empty;
        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State register; reset returns the line to idle and flushes the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            ready_q <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: tb/tb_uart_encoder.sv
// tb_uart_encoder: table-driven frames, burst, reset and stop-bit
// corner cases, plus random traffic decoded from the serial line.
module tb_uart_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
    logic       a_tx, b_tx;
    logic       a_busy, b_busy;
    logic [2:0] a_level, b_level;

    int   sel;
    logic tx_m, busy_m;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;

    vec_t vecs[8];
    logic [7:0] model_q[$];

    always #5 clk = ~clk;

    uart_encoder #(
        .CLK_FREQ_HZ(1000000), .BAUD(100000),
        .FIFO_DEPTH(4), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .rst(rst),
        .i_data(a_data), .i_valid(a_valid),
        .o_ready(a_ready), .o_tx(a_tx),
        .o_busy(a_busy), .o_level(a_level)
    );

    uart_encoder #(
        .CLK_FREQ_HZ(1000000), .BAUD(100000),
        .FIFO_DEPTH(4), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .rst(rst),
        .i_data(b_data), .i_valid(b_valid),
        .o_ready(b_ready), .o_tx(b_tx),
        .o_busy(b_busy), .o_level(b_level)
    );

    always_comb begin
        tx_m   = (sel != 0) ? b_tx : a_tx;
        busy_m = (sel != 0) ? b_busy : a_busy;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_fall(input int limit, output int n);
        n = 0;
        while (tx_m !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Compare every cycle of one frame against the ideal line waveform.
    // Entered on the first sample where the start bit is low.
    task automatic wave(input logic [9:0] line, input int nstop,
                        output int bad);
        logic e;
        bad = 0;
        for (int k = 0; k < (9 + nstop) * 10; k++) begin
            if (k != 0) @(negedge clk);
            e = (k < 100) ? line[k / 10] : 1'b1;
            if (tx_m !== e) bad++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, bad, i, acc, guard, sawfull, maxlvl, lows, sent, rdybad;
        logic [7:0] got;
        logic [7:0] exp_b;

        vecs[0] = '{8'h55, 10'b1010101010};
        vecs[1] = '{8'hA5, 10'b1101001010};
        vecs[2] = '{8'h3C, 10'b1001111000};
        vecs[3] = '{8'hFF, 10'b1111111110};
        vecs[4] = '{8'h00, 10'b1000000000};
        vecs[5] = '{8'h81, 10'b1100000010};
        vecs[6] = '{8'h7E, 10'b1011111100};
        vecs[7] = '{8'hF0, 10'b1111100000};

        sel = 0;
        rst = 1'b1;
        a_valid = 1'b0; a_data = 8'h00;
        b_valid = 1'b0; b_data = 8'h00;

        // Reset held for three edges
        @(posedge clk);
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            chk("rst_tx", a_tx, 1);
            chk("rst_ready", a_ready, 0);
            chk("rst_level", a_level, 0);
            chk("rst_busy", a_busy, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", a_ready, 1);
        chk("ready_after_rst_b", b_ready, 1);

        // Single frames from idle
        for (int v = 0; v < 8; v++) begin
            chk("vec_ready", a_ready, 1);
            a_data  = vecs[v].data;
            a_valid = 1'b1;
            @(negedge clk);
            a_valid = 1'b0;
            a_data  = 8'hXX;
            wait_fall(20, n);
            chk("vec_latency", n, 2);
            wave(vecs[v].line, 1, bad);
            chk("vec_wave", bad, 0);
            chk("vec_busy_last", busy_m, 1);
            @(negedge clk);
            chk("vec_busy_fall", busy_m, 0);
            chk("vec_tx_idle", tx_m, 1);
            repeat (3) @(negedge clk);
        end

        // Burst of six with valid held: FIFO fills, frames back-to-back
        fork
            begin
                i = 1; sawfull = 0; maxlvl = 0; guard = 0;
                while (i < 7 && guard < 3000) begin
                    a_data  = vecs[i].data;
                    a_valid = 1'b1;
                    acc = int'(a_ready);
                    if (int'(a_level) > maxlvl) maxlvl = int'(a_level);
                    if (!a_ready && a_level == 3'd4) sawfull = 1;
                    @(negedge clk);
                    if (acc != 0) i++;
                    guard++;
                end
                a_valid = 1'b0;
                chk("burst_all_taken", i, 7);
                chk("burst_full_seen", sawfull, 1);
                chk("burst_max_level", maxlvl, 4);
            end
            begin
                wait_fall(50, n);
                chk("burst_start", int'(n < 50), 1);
                for (int j = 1; j < 7; j++) begin
                    if (j > 1) begin
                        @(negedge clk);
                        chk("burst_no_gap", tx_m, 0);
                    end
                    wave(vecs[j].line, 1, bad);
                    chk("burst_wave", bad, 0);
                end
                @(negedge clk);
                chk("burst_end_tx", tx_m, 1);
                chk("burst_end_busy", busy_m, 0);
            end
        join
        repeat (5) @(negedge clk);

        // Reset during data bit 3 of 0xF0 with two bytes queued
        a_valid = 1'b1;
        a_data  = 8'hF0; @(negedge clk);
        a_data  = 8'h11; @(negedge clk);
        a_data  = 8'h22; @(negedge clk);
        a_valid = 1'b0;
        wait_fall(20, n);
        chk("mid_start", n, 0);
        repeat (45) @(negedge clk);
        chk("mid_bit3_low", tx_m, 0);
        chk("mid_level_pre", a_level, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", a_tx, 1);
        chk("mid_rst_level", a_level, 0);
        chk("mid_rst_busy", a_busy, 0);
        rst = 1'b0;
        lows = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (a_tx !== 1'b1) lows++;
        end
        chk("mid_no_restart", lows, 0);
        chk("mid_ready", a_ready, 1);

        // Two stop bits: 110-cycle frames, 20 high cycles between starts
        sel = 1;
        b_data  = 8'h00;
        b_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        wait_fall(20, n);
        chk("sb2_latency", n, 1);
        wave(vecs[4].line, 2, bad);
        chk("sb2_wave1", bad, 0);
        @(negedge clk);
        chk("sb2_gap", tx_m, 0);
        wave(vecs[4].line, 2, bad);
        chk("sb2_wave2", bad, 0);
        @(negedge clk);
        chk("sb2_busy_fall", busy_m, 0);
        sel = 0;

        // Random traffic with random valid gaps, decoded mid-bit
        sent = 0; rdybad = 0;
        fork
            begin
                guard = 0;
                while (sent < 20 && guard < 20000) begin
                    a_data  = 8'($urandom);
                    a_valid = ($urandom_range(0, 2) != 0);
                    acc = int'(a_valid && a_ready);
                    if (acc != 0) model_q.push_back(a_data);
                    if (a_ready != (a_level < 3'd4)) rdybad++;
                    @(negedge clk);
                    if (acc != 0) sent++;
                    guard++;
                end
                a_valid = 1'b0;
            end
            begin
                for (int r = 0; r < 20; r++) begin
                    wait_fall(3000, n);
                    if (n >= 3000) begin
                        chk("rand_timeout", n, 0);
                        break;
                    end
                    repeat (15) @(negedge clk);
                    for (int b = 0; b < 8; b++) begin
                        got[b] = tx_m;
                        if (b < 7) repeat (10) @(negedge clk);
                    end
                    repeat (10) @(negedge clk);
                    chk("rand_stop", tx_m, 1);
                    repeat (4) @(negedge clk);
                    if (model_q.size() == 0) begin
                        chk("rand_extra_frame", int'(got), -1);
                    end else begin
                        exp_b = model_q.pop_front();
                        chk("rand_byte", int'(got), int'(exp_b));
                    end
                end
            end
        join
        chk("rand_sent", sent, 20);
        chk("rand_ready_vs_level", rdybad, 0);
        chk("rand_queue_drained", model_q.size(), 0);
        repeat (5) @(negedge clk);
        chk("rand_busy_end", a_busy, 0);
        chk("rand_tx_end", a_tx, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
